// File: rtl/period_meter.sv
// period_meter: measures the number of clk cycles between a start event and a
// stop event, and hands the result downstream over a valid/ready handshake.
// The count saturates at 2^WIDTH-1, and m_overflow flags a saturated result.
// Optional build macro PERIOD_METER_INPUT_SYNC_EN treats start/stop as
// asynchronous levels. Each level passes through a 2-flop synchronizer and a
// rising-edge detector. This adds the same 3-cycle latency to both events.
module period_meter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic             flag, flag_next;
    logic [WIDTH-1:0] data_next;
    logic             ovf_next;
    logic             start_evt;
    logic             stop_evt;

`ifdef PERIOD_METER_INPUT_SYNC_EN
    logic [1:0] start_sync, stop_sync;
    logic       start_last, stop_last;
    logic [1:0] warm;
    logic       start_pulse, stop_pulse;

    // Synchronize the async levels and turn their rising edges into registered pulses.
    // The warm-up counter masks edges until the edge flop holds a real sample,
    // so a level that is already high at reset release produces no event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync  <= '0;
            stop_sync   <= '0;
            start_last  <= 1'b0;
            stop_last   <= 1'b0;
            warm        <= '0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
        end else begin
            start_sync  <= {start_sync[0], start};
            stop_sync   <= {stop_sync[0], stop};
            start_last  <= start_sync[1];
            stop_last   <= stop_sync[1];
            if (warm != 2'd3) warm <= warm + 2'd1;
            start_pulse <= (warm == 2'd3) && start_sync[1] && !start_last;
            stop_pulse  <= (warm == 2'd3) && stop_sync[1] && !stop_last;
        end
    end

    assign start_evt = start_pulse;
    assign stop_evt  = stop_pulse;
`else
    assign start_evt = start;
    assign stop_evt  = stop;
`endif

    // Outputs are decoded directly from the state register.
    assign busy    = (state == COUNT);
    assign m_valid = (state == HOLD);

    // Next-state and datapath decisions; clear overrides every other input.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        count_next = count;
        flag_next  = flag;
        data_next  = m_data;
        ovf_next   = m_overflow;
        if (clear) begin
            state_next = IDLE;
            count_next = '0;
            flag_next  = 1'b0;
            data_next  = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_evt) begin
                        count_next = {{(WIDTH-1){1'b0}}, 1'b1};
                        flag_next  = 1'b0;
                        state_next = COUNT;
                    end
                end
                COUNT: begin
                    if (stop_evt) begin
                        data_next  = count;
                        ovf_next   = flag;
                        state_next = HOLD;
                    end else if (start_evt) begin
                        count_next = {{(WIDTH-1){1'b0}}, 1'b1};
                        flag_next  = 1'b0;
                    end else if (count == CNT_MAX) begin
                        flag_next  = 1'b1;
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Count, overflow flag and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            flag       <= 1'b0;
            m_data     <= '0;
            m_overflow <= 1'b0;
        end else begin
            count      <= count_next;
            flag       <= flag_next;
            m_data     <= data_next;
            m_overflow <= ovf_next;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter. A timestamp-based reference model
// predicts the outputs. A measurement is the difference between the cycle
// index of the stop event and the cycle index of the start event, capped at
// 2^WIDTH-1. Directed scenarios run first, followed by random traffic.
module tb_period_meter;

    localparam int WIDTH = 5;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef PERIOD_METER_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             start;
    logic             stop;
    logic             busy;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_overflow;

    period_meter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_overflow (m_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int cyc       = 0;
    bit mdl_meas  = 0;
    bit mdl_hold  = 0;
    int t0        = 0;
    int exp_data  = 0;
    int exp_ovf   = 0;
    bit prev_s    = 0;
    bit prev_p    = 0;
    bit start_q[$];
    bit stop_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_meas = 0;
        mdl_hold = 0;
        exp_data = 0;
        exp_ovf  = 0;
        prev_s   = 0;
        prev_p   = 0;
        start_q.delete();
        stop_q.delete();
        for (int i = 0; i < LAT; i++) begin
            start_q.push_back(1'b0);
            stop_q.push_back(1'b0);
        end
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge(input bit st, input bit sp, input bit cl, input bit rdy);
        bit es, ep;
        int n;
        cyc++;
        if (LAT > 0) begin
            start_q.push_back(st && !prev_s);
            stop_q.push_back(sp && !prev_p);
            prev_s = st;
            prev_p = sp;
            es = start_q.pop_front();
            ep = stop_q.pop_front();
        end else begin
            es = st;
            ep = sp;
        end
        if (cl) begin
            mdl_meas = 0;
            mdl_hold = 0;
            exp_data = 0;
            exp_ovf  = 0;
        end else if (mdl_hold) begin
            if (rdy) mdl_hold = 0;
        end else if (mdl_meas) begin
            if (ep) begin
                n        = cyc - t0;
                exp_data = (n > MAXV) ? MAXV : n;
                exp_ovf  = (n > MAXV) ? 1 : 0;
                mdl_meas = 0;
                mdl_hold = 1;
            end else if (es) begin
                t0 = cyc;
            end
        end else if (es) begin
            mdl_meas = 1;
            t0       = cyc;
        end
    endtask

    task automatic compare_all();
        check("busy", int'(busy), int'(mdl_meas));
        check("m_valid", int'(m_valid), int'(mdl_hold));
        check("m_data", int'(m_data), exp_data);
        check("m_overflow", int'(m_overflow), exp_ovf);
    endtask

    // Drive inputs, take one edge, then check the outputs 1 time unit later.
    task automatic step(input bit st, input bit sp, input bit cl, input bit rdy);
        start   = st;
        stop    = sp;
        clear   = cl;
        m_ready = rdy;
        @(posedge clk);
        model_edge(st, sp, cl, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        start   = 1'b0;
        stop    = 1'b0;
        clear   = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_ovf", int'(m_overflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5, 1'b0);
    endtask

    // Start pulse, n-1 quiet edges, then a stop pulse.
    task automatic run_interval(input int n, input bit rdy);
        step(1'b1, 1'b0, 1'b0, rdy);
        idle(n - 1, rdy);
        step(1'b0, 1'b1, 1'b0, rdy);
    endtask

    // Bounded wait for m_valid; ready is held low so the result stays visible.
    task automatic wait_valid(input string tag);
        int k = 0;
        while (!m_valid && k < LAT + 4) begin
            idle(1, 1'b0);
            k++;
        end
        check(tag, int'(m_valid), 1);
    endtask

    task automatic accept();
        idle(1, 1'b1);
        idle(LAT + 2, 1'b1);
    endtask

    initial begin
        do_reset();

        // Reset in the middle of a measurement.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(4 + LAT, 1'b1);
        check("midcnt_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(m_valid), 0);
        check("midrst_data", int'(m_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(LAT + 3, 1'b1);
        check("midrst_novalid", int'(m_valid), 0);

        // Basic measurement of 7 cycles.
        run_interval(7, 1'b0);
        wait_valid("basic_seen");
        check("basic_data", int'(m_data), 7);
        check("basic_ovf", int'(m_overflow), 0);
        accept();
        check("basic_idle", int'(m_valid), 0);

        // Backpressure with a start pulse ignored during HOLD.
        run_interval(3, 1'b0);
        wait_valid("bp_seen");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("bp_data", int'(m_data), 3);
        check("bp_valid", int'(m_valid), 1);
        idle(LAT + 1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_after", int'(m_valid), 0);
        idle(LAT + 2, 1'b1);
        check("bp_nostart", int'(busy), 0);

        // Saturation, then a short measurement to clear the overflow.
        run_interval(40, 1'b0);
        wait_valid("sat_seen");
        check("sat_data", int'(m_data), MAXV);
        check("sat_ovf", int'(m_overflow), 1);
        accept();
        run_interval(MAXV, 1'b0);
        wait_valid("edge_seen");
        check("edge_data", int'(m_data), MAXV);
        check("edge_ovf", int'(m_overflow), 0);
        accept();
        run_interval(2, 1'b0);
        wait_valid("short_seen");
        check("short_data", int'(m_data), 2);
        check("short_ovf", int'(m_overflow), 0);
        accept();

        // Start and stop together in IDLE, then a restart at count 5.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        wait_valid("restart_seen");
        check("restart_data", int'(m_data), 3);
        accept();

        // Start and stop together in COUNT: capture wins.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        wait_valid("both_seen");
        check("both_data", int'(m_data), 3);
        accept();
        check("both_idle", int'(busy), 0);

        // Clear during HOLD.
        run_interval(4, 1'b0);
        wait_valid("clr_seen");
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_valid", int'(m_valid), 0);
        check("clr_data", int'(m_data), 0);
        idle(LAT + 2, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, ($urandom % 22) == 0,
                 ($urandom % 300) == 0, ($urandom % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
